// File: rtl/core_seq_fsm_if.sv
// Memory handshake bundle between the sequencer (master) and the
// instruction/data memories (slave).
interface core_seq_fsm_if;
  logic       imem_req;
  logic       imem_ack;
  logic [6:0] imem_opcode;
  logic       dmem_req;
  logic       dmem_ack;
  logic       DM_write_en;

  modport master (
    output imem_req, dmem_req, DM_write_en,
    input  imem_ack, imem_opcode, dmem_ack
  );

  modport slave (
    input  imem_req, dmem_req, DM_write_en,
    output imem_ack, imem_opcode, dmem_ack
  );
endinterface

// File: rtl/core_seq_fsm.sv
// Multi-cycle RV32I instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with
// variable-latency memory handshakes, retired-instruction counter and fault trap.
module core_seq_fsm #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  core_seq_fsm_if.master   bus,
  input  logic             branch_taken,
  output logic             ir_load,
  output logic             reg_write_en,
  output logic             pc_write_en,
  output logic             PC_MUX_sel,
  output logic             PC_stall,
  output logic [WIDTH-1:0] instret,
  output logic             fault,
  output logic [1:0]       fault_code
);

  localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] WCNT_LAST = WCW'(TIMEOUT - 1);

  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_ALUI  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  state_t           state_reg;
  logic [6:0]       op_reg;
  logic [WCW-1:0]   wcnt_reg;
  logic [WIDTH-1:0] instret_reg;
  logic             fault_reg;
  logic [1:0]       fault_code_reg;

  logic imem_req_next;
  logic dmem_req_next;
  logic dm_we_next;
  logic is_store;
  logic is_load;
  logic is_branch;
  logic is_jump;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_ALU, OP_ALUI, OP_LOAD, OP_JALR, OP_STORE,
      OP_BR, OP_AUIPC, OP_LUI, OP_JAL: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  assign is_store  = (op_reg == OP_STORE);
  assign is_load   = (op_reg == OP_LOAD);
  assign is_branch = (op_reg == OP_BR);
  assign is_jump   = (op_reg == OP_JAL) || (op_reg == OP_JALR);

  // wcnt is cleared on every transition, so it only counts consecutive waits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_FETCH;
      op_reg         <= '0;
      wcnt_reg       <= '0;
      instret_reg    <= '0;
      fault_reg      <= 1'b0;
      fault_code_reg <= 2'b00;
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (bus.imem_ack) begin
            op_reg    <= bus.imem_opcode;
            state_reg <= S_DECODE;
            wcnt_reg  <= '0;
          end else if (wcnt_reg == WCNT_LAST) begin
            state_reg      <= S_TRAP;
            fault_reg      <= 1'b1;
            fault_code_reg <= 2'b10;
            wcnt_reg       <= '0;
          end else begin
            wcnt_reg <= wcnt_reg + WCW'(1);
          end
        end
        S_DECODE: begin
          wcnt_reg <= '0;
          if (is_legal(op_reg)) begin
            state_reg <= S_EXEC;
          end else begin
            state_reg      <= S_TRAP;
            fault_reg      <= 1'b1;
            fault_code_reg <= 2'b01;
          end
        end
        S_EXEC: begin
          wcnt_reg  <= '0;
          state_reg <= (is_load || is_store) ? S_MEM : S_WB;
        end
        S_MEM: begin
          // An ack on the last allowed cycle still completes the access.
          if (bus.dmem_ack) begin
            state_reg <= S_WB;
            wcnt_reg  <= '0;
          end else if (wcnt_reg == WCNT_LAST) begin
            state_reg      <= S_TRAP;
            fault_reg      <= 1'b1;
            fault_code_reg <= 2'b11;
            wcnt_reg       <= '0;
          end else begin
            wcnt_reg <= wcnt_reg + WCW'(1);
          end
        end
        S_WB: begin
          instret_reg <= instret_reg + WIDTH'(1);
          wcnt_reg    <= '0;
          state_reg   <= S_FETCH;
        end
        S_TRAP: begin
          state_reg <= S_TRAP;
        end
        default: begin
          state_reg <= S_FETCH;
          wcnt_reg  <= '0;
        end
      endcase
    end
  end

  // Outputs are a pure decode of the state register and op_reg; reset masks
  // everything so nothing is enabled while the sequencer is being cleared.
  always_comb begin
    imem_req_next = 1'b0;
    dmem_req_next = 1'b0;
    dm_we_next    = 1'b0;
    ir_load       = 1'b0;
    reg_write_en  = 1'b0;
    pc_write_en   = 1'b0;
    PC_MUX_sel    = 1'b0;
    if (!rst) begin
      case (state_reg)
        S_FETCH: begin
          imem_req_next = 1'b1;
          ir_load       = bus.imem_ack;
        end
        S_MEM: begin
          dmem_req_next = 1'b1;
          dm_we_next    = is_store;
        end
        S_WB: begin
          pc_write_en  = 1'b1;
          reg_write_en = !(is_store || is_branch);
          PC_MUX_sel   = is_jump || (is_branch && branch_taken);
        end
        default: begin
          imem_req_next = 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = imem_req_next;
  assign bus.dmem_req    = dmem_req_next;
  assign bus.DM_write_en = dm_we_next;
  assign PC_stall        = ~pc_write_en;
  assign instret         = rst ? '0 : instret_reg;
  assign fault           = rst ? 1'b0 : fault_reg;
  assign fault_code      = rst ? 2'b00 : fault_code_reg;

endmodule
